// File: rtl/write_through_buffer.sv
// Write-through store buffer: circular FIFO of {addr, wdata, wstrb} drained to a back-end write channel.
// Optional tail-entry write merging when WTB_MERGE_EN is defined.
module write_through_buffer #(
    parameter int FE_ADDR_W = 32,
    parameter int FE_DATA_W = 32,
    parameter int DEPTH_W   = 2
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic                                                 push_valid,
    input  logic [FE_ADDR_W-$clog2(FE_DATA_W/8)-1:0]             push_addr,
    input  logic [FE_DATA_W-1:0]                                 push_wdata,
    input  logic [FE_DATA_W/8-1:0]                               push_wstrb,
    output logic                                                 full,
    output logic                                                 empty,
    output logic [DEPTH_W:0]                                     level,
    output logic                                                 write_valid,
    output logic [FE_ADDR_W-$clog2(FE_DATA_W/8)-1:0]             write_addr,
    output logic [FE_DATA_W-1:0]                                 write_wdata,
    output logic [FE_DATA_W/8-1:0]                               write_wstrb,
    input  logic                                                 write_ready
);
    localparam int FE_NBYTES = FE_DATA_W / 8;
    localparam int FE_BYTE_W = $clog2(FE_NBYTES);
    localparam int WA_W      = FE_ADDR_W - FE_BYTE_W;
    localparam int DEPTH     = 2 ** DEPTH_W;

    logic [DEPTH_W-1:0]                      wr_ptr_q, wr_ptr_d;
    logic [DEPTH_W-1:0]                      rd_ptr_q, rd_ptr_d;
    logic [DEPTH_W:0]                        level_q, level_d;
    logic [DEPTH-1:0][WA_W-1:0]              addr_q, addr_d;
    logic [DEPTH-1:0][FE_NBYTES-1:0][7:0]    data_q, data_d;
    logic [DEPTH-1:0][FE_NBYTES-1:0]         strb_q, strb_d;

    logic alloc;
    logic pop;

    assign full        = (level_q == (DEPTH_W+1)'(DEPTH));
    assign empty       = (level_q == '0);
    assign level       = level_q;
    assign write_valid = !empty;
    assign write_addr  = addr_q[rd_ptr_q];
    assign write_wdata = data_q[rd_ptr_q];
    assign write_wstrb = strb_q[rd_ptr_q];

    assign pop = write_valid && write_ready;

`ifdef WTB_MERGE_EN
    logic [DEPTH_W-1:0] tail_ptr;
    logic               merge;

    assign tail_ptr = wr_ptr_q - DEPTH_W'(1);
    // Tail is distinct from head only with two or more entries, so a merge
    // never alters data the back end may already be consuming.
    assign merge    = push_valid && (level_q >= (DEPTH_W+1)'(2))
                      && (push_addr == addr_q[tail_ptr]);
    assign alloc    = push_valid && !full && !merge;
`else
    assign alloc    = push_valid && !full;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        addr_d   = addr_q;
        data_d   = data_q;
        strb_d   = strb_q;

        if (alloc) begin
            addr_d[wr_ptr_q] = push_addr;
            data_d[wr_ptr_q] = push_wdata;
            strb_d[wr_ptr_q] = push_wstrb;
            wr_ptr_d         = wr_ptr_q + DEPTH_W'(1);
        end
`ifdef WTB_MERGE_EN
        if (merge) begin
            for (int i = 0; i < FE_NBYTES; i++) begin
                if (push_wstrb[i]) data_d[tail_ptr][i] = push_wdata[i*8 +: 8];
            end
            strb_d[tail_ptr] = strb_q[tail_ptr] | push_wstrb;
        end
`endif
        if (pop) rd_ptr_d = rd_ptr_q + DEPTH_W'(1);

        case ({alloc, pop})
            2'b10:   level_d = level_q + (DEPTH_W+1)'(1);
            2'b01:   level_d = level_q - (DEPTH_W+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Payload storage carries no reset; it is only observed while write_valid=1.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        strb_q <= strb_d;
    end

endmodule
